// File: rtl/dmem_responder.sv
// Data-memory responder: req/ack handshake, WAIT wait states, byte-enable writes.
// Optional build macro DMEM_RESPONDER_ALIGN_CHECK_EN flags addr[1:0]!=0 as an error.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT        = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   output logic        busy,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_d;

   logic            we_q;
   logic            bad_q;
   logic [AW-1:0]   idx_q;
   logic [31:0]     wdata_q;
   logic [3:0]      be_q;

   logic            misalign_c;
   logic            bad_c;
   logic            cur_we_c;
   logic            cur_bad_c;
   logic [AW-1:0]   cur_idx_c;
   logic [31:0]     cur_wdata_c;
   logic [3:0]      cur_be_c;

   logic            busy_d;
   logic            ack_d;
   logic [31:0]     rdata_d;
   logic            err_d;
   logic            mem_we_c;

   logic [31:0]     mem [DEPTH_WORDS];

`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
   assign misalign_c = (addr[1:0] != 2'b00);
`else
   logic unused_addr_lsb;
   assign misalign_c      = 1'b0;
   assign unused_addr_lsb = ^addr[1:0];
`endif

   // Out of range whenever any word-address bit above the index is set.
   assign bad_c = (addr[31:AW+2] != '0) | misalign_c;

   // With WAIT=0 the commit edge is also the accepting edge, so use the live request.
   always_comb begin
      if (state == ST_IDLE) begin
         cur_we_c    = we;
         cur_bad_c   = bad_c;
         cur_idx_c   = addr[AW+1:2];
         cur_wdata_c = wdata;
         cur_be_c    = be;
      end else begin
         cur_we_c    = we_q;
         cur_bad_c   = bad_q;
         cur_idx_c   = idx_q;
         cur_wdata_c = wdata_q;
         cur_be_c    = be_q;
      end
   end

   // State, wait counter and request capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         we_q    <= 1'b0;
         bad_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         state <= next_state;
         cnt   <= cnt_d;
         if (state == ST_IDLE && req) begin
            we_q    <= we;
            bad_q   <= bad_c;
            idx_q   <= addr[AW+1:2];
            wdata_q <= wdata;
            be_q    <= be;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      cnt_d      = cnt;
      case (state)
         ST_IDLE: begin
            if (req) begin
               cnt_d      = CW'(WAIT);
               next_state = (WAIT == 0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               next_state = ST_RESP;
            end
         end
         ST_RESP: begin
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Output logic; RESP never repeats, so entering RESP is the commit edge.
   always_comb begin
      busy_d   = (next_state != ST_IDLE);
      ack_d    = (next_state == ST_RESP);
      rdata_d  = rdata;
      err_d    = err;
      mem_we_c = 1'b0;
      if (ack_d) begin
         if (cur_bad_c) begin
            rdata_d = '0;
            err_d   = 1'b1;
         end else if (cur_we_c) begin
            err_d    = 1'b0;
            mem_we_c = ~rst;
         end else begin
            rdata_d = mem[cur_idx_c];
            err_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy  <= 1'b0;
         ack   <= 1'b0;
         rdata <= '0;
         err   <= 1'b0;
      end else begin
         busy  <= busy_d;
         ack   <= ack_d;
         rdata <= rdata_d;
         err   <= err_d;
      end
   end

   // Storage is not reset; only enabled lanes are written.
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         for (int i = 0; i < 4; i++) begin
            if (cur_be_c[i]) begin
               mem[cur_idx_c][8*i +: 8] <= cur_wdata_c[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with WAIT = 0, 2 and 3.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req2, req3;
   logic        we;
   logic [31:0] addr, wdata;
   logic [3:0]  be;
   logic        busy0, ack0, err0;
   logic        busy2, ack2, err2;
   logic        busy3, ack3, err3;
   logic [31:0] rdata0, rdata2, rdata3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(256), .WAIT(0)) u_w0 (
      .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .wdata(wdata), .be(be),
      .busy(busy0), .ack(ack0), .rdata(rdata0), .err(err0));
   dmem_responder #(.DEPTH_WORDS(256), .WAIT(2)) u_w2 (
      .clk(clk), .rst(rst), .req(req2), .we(we), .addr(addr), .wdata(wdata), .be(be),
      .busy(busy2), .ack(ack2), .rdata(rdata2), .err(err2));
   dmem_responder #(.DEPTH_WORDS(256), .WAIT(3)) u_w3 (
      .clk(clk), .rst(rst), .req(req3), .we(we), .addr(addr), .wdata(wdata), .be(be),
      .busy(busy3), .ack(ack3), .rdata(rdata3), .err(err3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int sel, input logic v);
      case (sel)
         0:       req0 = v;
         2:       req2 = v;
         default: req3 = v;
      endcase
   endtask

   function automatic logic ack_of(input int sel);
      case (sel)
         0:       return ack0;
         2:       return ack2;
         default: return ack3;
      endcase
   endfunction

   function automatic logic [31:0] rdata_of(input int sel);
      case (sel)
         0:       return rdata0;
         2:       return rdata2;
         default: return rdata3;
      endcase
   endfunction

   function automatic logic err_of(input int sel);
      case (sel)
         0:       return err0;
         2:       return err2;
         default: return err3;
      endcase
   endfunction

   // One request from an idle instance; lat counts edges from the accepting edge to ack.
   task automatic xfer(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output int lat, output logic [31:0] rd, output logic er);
      we = w; addr = a; wdata = d; be = b;
      set_req(sel, 1'b1);
      lat = 0; rd = 'x; er = 1'bx;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); @(negedge clk);
         if (n == 1) set_req(sel, 1'b0);
         if (ack_of(sel)) begin
            lat = n; rd = rdata_of(sel); er = err_of(sel);
            break;
         end
      end
      set_req(sel, 1'b0);
      @(posedge clk); @(negedge clk);
      chk("ack_one_cycle", 32'(ack_of(sel)), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      int          acks;
      int          k;
      logic [31:0] rd;
      logic        er;
      logic [9:0]  ackpat;

      rst = 1'b1; req0 = 1'b0; req2 = 1'b0; req3 = 1'b0;
      we = 1'b0; addr = '0; wdata = '0; be = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy",  32'(busy2), 32'd0);
      chk("rst_ack",   32'(ack2),  32'd0);
      chk("rst_err",   32'(err2),  32'd0);
      chk("rst_rdata", rdata2,     32'd0);
      chk("rst_busy_w0", 32'(busy0), 32'd0);
      chk("rst_busy_w3", 32'(busy3), 32'd0);

      // Full-word write then read, WAIT=2.
      xfer(2, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, lat, rd, er);
      chk("wr_lat", 32'(lat), 32'd3);
      chk("wr_err", 32'(er),  32'd0);
      xfer(2, 1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, er);
      chk("rd_lat",   32'(lat), 32'd3);
      chk("rd_data",  rd,       32'hDEADBEEF);
      chk("rd_err",   32'(er),  32'd0);

      // Byte-lane write keeps rdata; be=0000 acks and changes nothing.
      xfer(2, 1'b1, 32'h10, 32'h11223344, 4'b0101, lat, rd, er);
      chk("lane_wr_err",   32'(er), 32'd0);
      chk("lane_wr_rdata", rd,      32'hDEADBEEF);
      xfer(2, 1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, er);
      chk("lane_rd", rd, 32'hDE22BE44);
      xfer(2, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, lat, rd, er);
      chk("be0_lat", 32'(lat), 32'd3);
      chk("be0_err", 32'(er),  32'd0);
      xfer(2, 1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, er);
      chk("be0_rd", rd, 32'hDE22BE44);

      // Out of range: 0x400 would alias word 0 if the range check were missing.
      xfer(2, 1'b1, 32'h0, 32'h01234567, 4'b1111, lat, rd, er);
      xfer(2, 1'b1, 32'h400, 32'hBAD0BAD0, 4'b1111, lat, rd, er);
      chk("oor_wr_err",   32'(er), 32'd1);
      chk("oor_wr_rdata", rd,      32'd0);
      chk("oor_wr_lat",   32'(lat), 32'd3);
      xfer(2, 1'b0, 32'h0, 32'h0, 4'b0000, lat, rd, er);
      chk("oor_neigh", rd, 32'h01234567);
      chk("oor_neigh_err", 32'(er), 32'd0);
      xfer(2, 1'b0, 32'h400, 32'h0, 4'b0000, lat, rd, er);
      chk("oor_rd_err",   32'(er), 32'd1);
      chk("oor_rd_rdata", rd,      32'd0);
      xfer(2, 1'b1, 32'h3FC, 32'h5A5A5A5A, 4'b1111, lat, rd, er);
      xfer(2, 1'b0, 32'h3FC, 32'h0, 4'b0000, lat, rd, er);
      chk("last_word",     rd,      32'h5A5A5A5A);
      chk("last_word_err", 32'(er), 32'd0);

      xfer(2, 1'b0, 32'h12, 32'h0, 4'b0000, lat, rd, er);
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
      chk("misalign_err",   32'(er), 32'd1);
      chk("misalign_rdata", rd,      32'd0);
`else
      chk("unaligned_err",   32'(er), 32'd0);
      chk("unaligned_rdata", rd,      32'hDE22BE44);
`endif

      // Asynchronous reset mid-cycle during a write in WAIT.
      xfer(2, 1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, er);
      chk("pre_rst_rd", rd, 32'hDE22BE44);
      we = 1'b1; addr = 32'h10; wdata = 32'h0; be = 4'b1111; req2 = 1'b1;
      @(posedge clk);
      #2;
      chk("busy_after_accept", 32'(busy2), 32'd1);
      rst = 1'b1;
      #1;
      chk("async_busy",  32'(busy2), 32'd0);
      chk("async_ack",   32'(ack2),  32'd0);
      chk("async_err",   32'(err2),  32'd0);
      chk("async_rdata", rdata2,     32'd0);
      @(negedge clk); req2 = 1'b0;
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      xfer(2, 1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, er);
      chk("abort_no_write", rd, 32'hDE22BE44);

      // req pulse while busy is ignored.
      we = 1'b0; addr = 32'h10; be = 4'b0000; req2 = 1'b1; acks = 0;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); @(negedge clk);
         if (n == 0) begin
            req2 = 1'b0;
            chk("busy_in_wait", 32'(busy2), 32'd1);
         end
         if (n == 1) req2 = 1'b1;
         if (n == 2) req2 = 1'b0;
         acks += int'(ack2);
      end
      chk("busy_pulse_acks", 32'(acks), 32'd1);

      // Back-to-back writes, WAIT=0, req held high.
      k = 0; we = 1'b1; addr = 32'h0; wdata = 32'h10000000; be = 4'b1111; req0 = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); @(negedge clk);
         ackpat[n] = ack0;
         if (ack0) begin
            k++;
            if (k == 4) req0 = 1'b0;
            else begin
               addr  = 32'(4 * k);
               wdata = 32'h10000000 + 32'(k);
            end
         end
      end
      chk("b2b_ack_pattern", 32'(ackpat), 32'h055);
      for (int i = 0; i < 4; i++) begin
         xfer(0, 1'b0, 32'(4 * i), 32'h0, 4'b0000, lat, rd, er);
         chk("w0_lat",  32'(lat), 32'd1);
         chk("w0_data", rd,       32'h10000000 + 32'(i));
         chk("w0_err",  32'(er),  32'd0);
      end

      // Reset two cycles after acceptance, WAIT=3.
      xfer(3, 1'b1, 32'h20, 32'h55555555, 4'b1111, lat, rd, er);
      chk("w3_lat", 32'(lat), 32'd4);
      we = 1'b1; addr = 32'h20; wdata = 32'hAAAAAAAA; be = 4'b1111; req3 = 1'b1; acks = 0;
      @(posedge clk); @(negedge clk); req3 = 1'b0; acks += int'(ack3);
      @(posedge clk); @(negedge clk); acks += int'(ack3);
      @(posedge clk); #2 rst = 1'b1;
      @(negedge clk); acks += int'(ack3);
      @(posedge clk); @(negedge clk); rst = 1'b0; acks += int'(ack3);
      repeat (6) begin
         @(posedge clk); @(negedge clk);
         acks += int'(ack3);
      end
      chk("w3_abort_acks", 32'(acks),  32'd0);
      chk("w3_abort_busy", 32'(busy3), 32'd0);
      xfer(3, 1'b0, 32'h20, 32'h0, 4'b0000, lat, rd, er);
      chk("w3_prior_value", rd, 32'h55555555);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
